frame_buffer_reader: RTL and testbench

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

---
 rtl/colorspace_pkg.sv | 30 +++
 rtl/pixel_skid_buffer.sv | 80 ++++++++
 rtl/frame_buffer_reader.sv | 135 +++++++++++++
 tb/tb_frame_buffer_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/colorspace_pkg.sv
// Shared colorspace / frame-buffer constants.
//   - Default frame geometry shared by frame_buffer and frame_buffer_reader.
//   - State encodings for the frame_buffer_reader FSM.
//   - pixel_flags_t: per-pixel sideband carried next to the pixel data.
//   - clog2_min1(): address width helper that never returns 0, so a
//     one-row or one-column frame still gets a 1-bit address port.
package colorspace_pkg;

    // Default frame geometry (frame_buffer and its reader must agree).
    localparam int FB_DEFAULT_COLUMNS     = 640;
    localparam int FB_DEFAULT_ROWS        = 4;
    localparam int FB_DEFAULT_PIXEL_DEPTH = 8;

    // frame_buffer_reader FSM encodings.
    localparam logic [1:0] FBR_STATE_IDLE  = 2'd0;
    localparam logic [1:0] FBR_STATE_READ  = 2'd1;
    localparam logic [1:0] FBR_STATE_DRAIN = 2'd2;
    localparam logic [1:0] FBR_STATE_DONE  = 2'd3;

    // Sideband that travels with each pixel through the read pipeline.
    typedef struct packed {
        logic end_of_row;
        logic last;
    } pixel_flags_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry FIFO sitting between the frame buffer read port and the
// downstream ready/valid interface.
//   I_CLK, I_RESET : clock, synchronous active-high reset
//   push/push_data : write one entry (accepted when not full, or full
//                    with a simultaneous pop)
//   pop            : remove the head entry (ignored when empty)
//   head_data      : oldest entry; head_valid when at least one entry
//   count          : current occupancy 0..2
module pixel_skid_buffer #(
    parameter int P_WIDTH = 8
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] head_data,
    output logic               head_valid,
    output logic [1:0]         count
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        // When full, a push is only legal because the head leaves this cycle;
        // the slot written is the one being popped.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [P_WIDTH-1:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (do_push && (wr_ptr_q == 1'(gi))) begin
                    data_d = push_data;
                end
            end

            // Entries are cleared on reset so the head reads as zero.
            always_ff @(posedge I_CLK) begin
                if (I_RESET) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    assign head_data  = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;

endmodule

// File: rtl/frame_buffer_reader.sv
// Reads one full frame out of the frame buffer in raster order and streams
// it downstream over a ready/valid interface.
//   I_CLK, I_RESET   : clock, synchronous active-high reset
//   I_START          : request one frame (honoured only when idle)
//   I_PIXEL          : frame buffer read data, one cycle after O_READ_ENABLE
//   I_READY          : downstream accepts O_PIXEL this cycle
//   O_ROW, O_COLUMN  : frame buffer address (next address when not reading)
//   O_READ_ENABLE    : frame buffer read strobe
//   O_PIXEL, O_VALID : downstream pixel and its valid
//   O_END_OF_ROW     : O_PIXEL is the last column of its row
//   O_LAST           : O_PIXEL is the last pixel of the frame
//   O_BUSY           : frame read in progress (frame buffer writes blocked)
//   O_DONE           : one-cycle pulse after the last pixel is accepted
module frame_buffer_reader
    import colorspace_pkg::*;
#(
    parameter int  P_COLUMNS     = FB_DEFAULT_COLUMNS,
    parameter int  P_ROWS        = FB_DEFAULT_ROWS,
    parameter int  P_PIXEL_DEPTH = FB_DEFAULT_PIXEL_DEPTH,
    localparam int COL_W         = clog2_min1(P_COLUMNS),
    localparam int ROW_W         = clog2_min1(P_ROWS)
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_START,
    input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                     I_READY,
    output logic [COL_W-1:0]         O_COLUMN,
    output logic [ROW_W-1:0]         O_ROW,
    output logic                     O_READ_ENABLE,
    output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
    output logic                     O_VALID,
    output logic                     O_END_OF_ROW,
    output logic                     O_LAST,
    output logic                     O_BUSY,
    output logic                     O_DONE
);

    localparam int FIFO_W = P_PIXEL_DEPTH + $bits(pixel_flags_t);

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             pend_q, pend_d;          // read data arrives on I_PIXEL this cycle
    pixel_flags_t     pend_flags_q, pend_flags_d;

    logic             rd_en;
    logic             xfer;
    logic             col_last, row_last;
    logic [2:0]       credit;

    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_valid;
    logic [1:0]        fifo_count;
    pixel_flags_t      head_flags;

    pixel_skid_buffer #(
        .P_WIDTH(FIFO_W)
    ) u_skid (
        .I_CLK     (I_CLK),
        .I_RESET   (I_RESET),
        .push      (pend_q),
        .push_data ({pend_flags_q, I_PIXEL}),
        .pop       (I_READY),
        .head_data (fifo_head),
        .head_valid(fifo_valid),
        .count     (fifo_count)
    );

    assign head_flags = fifo_head[FIFO_W-1 -: $bits(pixel_flags_t)];

    always_comb begin
        xfer     = fifo_valid && I_READY;
        col_last = (col_q == COL_W'(P_COLUMNS - 1));
        row_last = (row_q == ROW_W'(P_ROWS - 1));
        // Pixels already owed to the FIFO (buffered + returning) minus the one
        // leaving now; one more read is allowed only if it still fits in two.
        credit   = 3'(fifo_count) + 3'(pend_q) - 3'(xfer);
        rd_en    = (state_q == FBR_STATE_READ) && (credit < 3'd2);

        state_d = state_q;
        case (state_q)
            FBR_STATE_IDLE:  if (I_START) state_d = FBR_STATE_READ;
            FBR_STATE_READ:  if (rd_en && col_last && row_last) state_d = FBR_STATE_DRAIN;
            FBR_STATE_DRAIN: if (xfer && head_flags.last) state_d = FBR_STATE_DONE;
            FBR_STATE_DONE:  state_d = FBR_STATE_IDLE;
            default:         state_d = FBR_STATE_IDLE;
        endcase

        // Address registers always show the next address to issue; the final
        // issue wraps them back to (0,0) for the next frame.
        col_d = col_q;
        row_d = row_q;
        if (rd_en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        pend_d                  = rd_en;
        pend_flags_d.end_of_row = rd_en && col_last;
        pend_flags_d.last       = rd_en && col_last && row_last;
    end

    // Clearing pend_q on reset drops any read issued while reset was asserted.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q      <= FBR_STATE_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pend_q       <= 1'b0;
            pend_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pend_q       <= pend_d;
            pend_flags_q <= pend_flags_d;
        end
    end

    assign O_COLUMN      = col_q;
    assign O_ROW         = row_q;
    assign O_READ_ENABLE = rd_en;
    assign O_PIXEL       = fifo_head[P_PIXEL_DEPTH-1:0];
    assign O_VALID       = fifo_valid;
    assign O_END_OF_ROW  = head_flags.end_of_row;
    assign O_LAST        = head_flags.last;
    assign O_BUSY        = (state_q == FBR_STATE_READ) || (state_q == FBR_STATE_DRAIN);
    assign O_DONE        = (state_q == FBR_STATE_DONE);

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: a 4x2 instance driven through several
// ready patterns and a 4x1 instance for the single-row case. A behavioural
// frame buffer returns row*16+column one cycle after each read.
module tb_frame_buffer_reader;

    localparam int C = 4;
    localparam int R = 2;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, start1, ready;
    logic [D-1:0] pix, opix, pix1, opix1;
    logic [1:0]   col, col1;
    logic [0:0]   row, row1;
    logic         rd, valid, eor, last, busy, done;
    logic         rd1, valid1, eor1, last1, busy1, done1;

    frame_buffer_reader #(.P_COLUMNS(C), .P_ROWS(R), .P_PIXEL_DEPTH(D)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_PIXEL(pix), .I_READY(ready),
        .O_COLUMN(col), .O_ROW(row), .O_READ_ENABLE(rd), .O_PIXEL(opix), .O_VALID(valid),
        .O_END_OF_ROW(eor), .O_LAST(last), .O_BUSY(busy), .O_DONE(done)
    );

    frame_buffer_reader #(.P_COLUMNS(C), .P_ROWS(1), .P_PIXEL_DEPTH(D)) dut1 (
        .I_CLK(clk), .I_RESET(rst), .I_START(start1), .I_PIXEL(pix1), .I_READY(ready),
        .O_COLUMN(col1), .O_ROW(row1), .O_READ_ENABLE(rd1), .O_PIXEL(opix1), .O_VALID(valid1),
        .O_END_OF_ROW(eor1), .O_LAST(last1), .O_BUSY(busy1), .O_DONE(done1)
    );

    // Frame buffer model: registered read, garbage when not reading.
    always @(posedge clk) begin
        pix  <= rd  ? 8'(int'(row) * 16 + int'(col)) : 8'($urandom);
        pix1 <= rd1 ? 8'(int'(row1) * 16 + int'(col1)) : 8'($urandom);
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state for dut
    logic [D+1:0] exp_q[$];      // {end_of_row, last, pixel} in delivery order
    int           rd_idx, outstanding, xfers, done_cnt;
    bit           busy_exp, done_exp, prev_stall;
    logic [D+1:0] prev_head;
    bit           v_valid, v_rd, v_done, v_xfer;
    logic [D-1:0] v_pix;

    task automatic model_clear();
        exp_q.delete();
        rd_idx = 0; outstanding = 0;
        busy_exp = 0; done_exp = 0; prev_stall = 0; prev_head = '0;
    endtask

    task automatic fill_frame();
        logic [D+1:0] e;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                e[D-1:0] = 8'(r * 16 + c);
                e[D+1]   = (c == C - 1);
                e[D]     = (c == C - 1) && (r == R - 1);
                exp_q.push_back(e);
            end
        end
        rd_idx = 0;
    endtask

    task automatic tick(input bit s, input bit r);
        logic [D+1:0] head, want;
        bit           done_next;
        @(negedge clk);
        start = s;
        ready = r;
        #1;
        head    = {eor, last, opix};
        v_valid = valid; v_rd = rd; v_done = done; v_pix = opix;
        v_xfer  = valid && ready;
        chk("busy", busy, busy_exp);
        chk("done", done, done_exp);
        if (rd) begin
            chk("rd_in_frame", rd_idx < C * R, 1);
            chk("rd_row", row, rd_idx / C);
            chk("rd_col", col, rd_idx % C);
            rd_idx++;
            outstanding++;
        end
        if (prev_stall) begin
            chk("hold_valid", valid, 1);
            chk("hold_data", head, prev_head);
        end
        done_next = 0;
        if (valid && ready) begin
            chk("queue_nonempty", exp_q.size() > 0, 1);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("pixel", head, want);
            outstanding--;
            xfers++;
            done_next = want[D];
        end
        chk("buffered_le2", outstanding <= 2, 1);
        if (done) done_cnt++;
        if (s && !busy_exp && !done_exp) begin
            fill_frame();
            busy_exp = 1;
        end else if (done_next) begin
            busy_exp = 0;
        end
        done_exp   = done_next;
        prev_stall = valid && !ready;
        prev_head  = head;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_pixel"}, opix, 0);
        chk({tag, "_eor"}, eor, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd"}, rd, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_col"}, col, 0);
    endtask

    initial begin
        int n, d1;
        rst = 1; start = 0; start1 = 0; ready = 1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_valid1", valid1, 0);
        rst = 0;

        // 1: ready held high
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1);
            if (i == 2) chk("t1_no_valid_c2", v_valid, 0);
            if (i == 3) chk("t1_first_pix_c3", {v_valid, v_pix}, {1'b1, 8'h00});
            if (i >= 3 && i <= 10) chk("t1_no_bubble", v_valid, 1);
            if (i == 11) chk("t1_done_c11", v_done, 1);
        end
        chk("t1_xfers", xfers, 8);
        chk("t1_done_once", done_cnt, 1);
        $display("t1 ready-high: %0d transfers, %0d done pulses", xfers, done_cnt);

        // 2: stall cycles 4..9
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            tick(i == 0, !(i >= 4 && i <= 9));
            if (i >= 4 && i <= 9) begin
                chk("t2_hold_01", {v_valid, v_pix}, {1'b1, 8'h01});
                chk("t2_no_read", v_rd, 0);
            end
        end
        chk("t2_xfers", xfers, 8);
        chk("t2_done_once", done_cnt, 1);
        $display("t2 stall 4-9: %0d transfers, %0d done pulses", xfers, done_cnt);

        // 3: ready toggling 1,0
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 30; i++) tick(i == 0, (i % 2) == 0);
        chk("t3_xfers", xfers, 8);
        chk("t3_done_once", done_cnt, 1);
        $display("t3 toggle: %0d transfers, %0d done pulses", xfers, done_cnt);

        // 4: random ready, extra start pulses mid-frame
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) tick(i == 0 || i == 5 || i == 9, $urandom_range(3) != 0);
        chk("t4_xfers", xfers, 8);
        chk("t4_done_once", done_cnt, 1);
        $display("t4 random ready + restart pulses: %0d transfers, %0d done pulses", xfers, done_cnt);

        // 5: reset after the 5th transfer, then a fresh frame
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 40 && xfers < 5; i++) tick(i == 0, 1);
        chk("t5_reached_5", xfers, 5);
        @(negedge clk);
        rst = 1; start = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk_all_zero("t5_after_reset");
        model_clear();
        xfers = 0; done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1);
            if (v_xfer && xfers == 1) chk("t5_first_after_reset", v_pix, 8'h00);
        end
        chk("t5_xfers", xfers, 8);
        chk("t5_done_once", done_cnt, 1);
        $display("t5 mid-frame reset: %0d transfers after restart", xfers);

        // 6: single-row instance
        n = 0; d1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start1 = (i == 0);
            ready  = 1;
            #1;
            if (done1) d1++;
            if (valid1 && ready) begin
                chk("t6_pixel", opix1, 8'(n));
                chk("t6_eor", eor1, n == C - 1);
                chk("t6_last", last1, n == C - 1);
                n++;
            end
        end
        chk("t6_count", n, C);
        chk("t6_done_once", d1, 1);
        $display("t6 single row: %0d pixels, %0d done pulses", n, d1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
